// File: rtl/fsm_link_pkg.sv
// rtl/fsm_link_pkg.sv - shared link encodings, host FSM states and steering map
package fsm_link_pkg;

  localparam int LINK_N       = 64;
  localparam int LINK_N_WIDTH = 4;
  localparam int LINK_MAX_OPS = 16;
  localparam int LINK_TIMEOUT = 64;
  localparam int NIBBLES      = LINK_N / LINK_N_WIDTH;

  typedef enum logic [3:0] {
    LS_S0     = 4'd0,
    LS_S1     = 4'd1,
    LS_S2     = 4'd2,
    LS_S3     = 4'd3,
    LS_S4     = 4'd4,
    LS_S5     = 4'd5,
    LS_S6     = 4'd6,
    LS_S7     = 4'd7,
    LS_IDLE   = 4'd8,
    LS_INPUT  = 4'd9,
    LS_OUTPUT = 4'd10
  } link_state_e;

  typedef enum logic [2:0] {
    H_IDLE,
    H_START,
    H_LOAD,
    H_OPS,
    H_STEER,
    H_CAPTURE,
    H_RESP
  } host_state_e;

  // Fixed walk from any operand state to OUTPUT in at most five hops.
  function automatic logic [1:0] steer(input logic [3:0] st);
    logic [1:0] op;
    case (st)
      LS_S0, LS_S1, LS_S2, LS_S3: op = 2'd2;
      LS_S4:                      op = 2'd1;
      default:                    op = 2'd0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fsm_link_deser.sv
// rtl/fsm_link_deser.sv - result nibble capture register with index and window timeout
module fsm_link_deser
  import fsm_link_pkg::*;
#(
  parameter int N       = LINK_N,
  parameter int N_WIDTH = LINK_N_WIDTH,
  parameter int TIMEOUT = LINK_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic               out_valid,
  input  logic [N_WIDTH-1:0] out_nib,
  output logic [N-1:0]       result,
  output logic               done,
  output logic               timeout
);

  localparam int NIB   = N / N_WIDTH;
  localparam int NIB_W = $clog2(NIB);
  localparam int TO_W  = $clog2(TIMEOUT);

  logic [N-1:0]     result_q, result_d;
  logic [NIB_W-1:0] k_q, k_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;

  assign done    = en && out_valid && (k_q == NIB_W'(NIB - 1));
  assign timeout = en && !done && (cnt_q == TO_W'(TIMEOUT - 1));
  assign result  = result_q;

  always_comb begin
    result_d = result_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    if (clr) begin
      result_d = '0;
      k_d      = '0;
      cnt_d    = '0;
    end else if (en) begin
      if (out_valid) begin
        result_d[k_q*N_WIDTH +: N_WIDTH] = out_nib;
        if (k_q != NIB_W'(NIB - 1)) k_d = k_q + NIB_W'(1);
      end
      if (cnt_q != TO_W'(TIMEOUT - 1)) cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
    end else begin
      result_q <= result_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fsm_link_host.sv
// rtl/fsm_link_host.sv - nibble-serial host master: load operands, run ops, steer to OUTPUT, capture result
module fsm_link_host
  import fsm_link_pkg::*;
#(
  parameter int N       = LINK_N,
  parameter int N_WIDTH = LINK_N_WIDTH,
  parameter int MAX_OPS = LINK_MAX_OPS,
  parameter int TIMEOUT = LINK_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [N-1:0]                 cmd_a,
  input  logic [N-1:0]                 cmd_b,
  input  logic [2*MAX_OPS-1:0]         cmd_ops,
  input  logic [$clog2(MAX_OPS+1)-1:0] cmd_op_count,
  output logic                         rsp_valid,
  output logic [N-1:0]                 rsp_result,
  output logic                         rsp_error,
  output logic                         busy,
  output logic                         link_start,
  output logic                         link_input_enable,
  output logic [N_WIDTH-1:0]           link_a,
  output logic [N_WIDTH-1:0]           link_b,
  output logic [1:0]                   link_op_val,
  input  logic [3:0]                   link_state,
  input  logic                         link_output_valid,
  input  logic [N_WIDTH-1:0]           link_out
);

  localparam int NIB   = N / N_WIDTH;
  localparam int NIB_W = $clog2(NIB);
  localparam int OPC_W = $clog2(MAX_OPS + 1);
  localparam int TO_W  = $clog2(TIMEOUT);

  host_state_e          state_q, state_d;
  logic [N-1:0]         a_q, a_d, b_q, b_d;
  logic [2*MAX_OPS-1:0] ops_q, ops_d;
  logic [OPC_W-1:0]     opc_q, opc_d, idx_q, idx_d;
  logic [NIB_W-1:0]     nib_q, nib_d;
  logic [TO_W-1:0]      steer_cnt_q, steer_cnt_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 at_output;
  logic                 cap_en, cap_done, cap_timeout;
  logic [N-1:0]         cap_result;

  assign accept    = (state_q == H_IDLE) && cmd_valid;
  assign at_output = (link_state == LS_OUTPUT);
  // The STEER cycle that first sees OUTPUT already belongs to the capture window.
  assign cap_en    = ((state_q == H_STEER) && at_output) || (state_q == H_CAPTURE);

  fsm_link_deser #(
    .N       (N),
    .N_WIDTH (N_WIDTH),
    .TIMEOUT (TIMEOUT)
  ) u_deser (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (cap_en),
    .out_valid (link_output_valid),
    .out_nib   (link_out),
    .result    (cap_result),
    .done      (cap_done),
    .timeout   (cap_timeout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    ops_d       = ops_q;
    opc_d       = opc_q;
    idx_d       = idx_q;
    nib_d       = nib_q;
    steer_cnt_d = steer_cnt_q;
    err_d       = err_q;
    unique case (state_q)
      H_IDLE: begin
        if (cmd_valid) begin
          a_d         = cmd_a;
          b_d         = cmd_b;
          ops_d       = cmd_ops;
          opc_d       = (cmd_op_count > OPC_W'(MAX_OPS)) ? OPC_W'(MAX_OPS) : cmd_op_count;
          idx_d       = '0;
          nib_d       = '0;
          steer_cnt_d = '0;
          err_d       = 1'b0;
          state_d     = H_START;
        end
      end
      H_START: state_d = H_LOAD;
      H_LOAD: begin
        if (nib_q == NIB_W'(NIB - 1)) state_d = (opc_q == '0) ? H_STEER : H_OPS;
        else                          nib_d   = nib_q + NIB_W'(1);
      end
      H_OPS: begin
        if (idx_q == opc_q - OPC_W'(1)) state_d = H_STEER;
        else                            idx_d   = idx_q + OPC_W'(1);
      end
      H_STEER: begin
        if (at_output) begin
          state_d = H_CAPTURE;
        end else if (steer_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = H_RESP;
          err_d   = 1'b1;
        end else begin
          steer_cnt_d = steer_cnt_q + TO_W'(1);
        end
      end
      H_CAPTURE: begin
        if (cap_done) begin
          state_d = H_RESP;
        end else if (cap_timeout) begin
          state_d = H_RESP;
          err_d   = 1'b1;
        end
      end
      H_RESP:  state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= H_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ops_q       <= '0;
      opc_q       <= '0;
      idx_q       <= '0;
      nib_q       <= '0;
      steer_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ops_q       <= ops_d;
      opc_q       <= opc_d;
      idx_q       <= idx_d;
      nib_q       <= nib_d;
      steer_cnt_q <= steer_cnt_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready         = (state_q == H_IDLE);
  assign busy              = (state_q != H_IDLE);
  assign rsp_valid         = (state_q == H_RESP);
  assign rsp_error         = (state_q == H_RESP) && err_q;
  assign rsp_result        = cap_result;
  assign link_start        = (state_q == H_START);
  assign link_input_enable = (state_q == H_LOAD);
  assign link_a = (state_q == H_LOAD) ? a_q[nib_q*N_WIDTH +: N_WIDTH] : '0;
  assign link_b = (state_q == H_LOAD) ? b_q[nib_q*N_WIDTH +: N_WIDTH] : '0;

  always_comb begin
    link_op_val = 2'd0;
    if (state_q == H_OPS)        link_op_val = ops_q[idx_q*2 +: 2];
    else if (state_q == H_STEER) link_op_val = steer(link_state);
  end

endmodule

// File: doc/fsm_link_host.md
Name: fsm_link_host

Overview:
- Host-side master for the nibble-serial compute link that fronts the 8-state operand FSM core.
- Accepts a 64-bit operand pair and a programmed op_val sequence on a valid/ready command port.
- Serializes operands into 4-bit nibbles and drives the op program.
- Steers the core into its OUTPUT state, deserializes the 16-nibble result, and returns it on a response port.
- Used by the bring-up harness and the on-board controller that sits opposite the chip pins.

Parameters:
N, 64, operand/result width in bits
N_WIDTH, 4, link nibble width; N/N_WIDTH = 16 nibbles per word
MAX_OPS, 16, maximum op_val steps per command
TIMEOUT, 64, cycle limit for the STEER phase and for the CAPTURE phase, each counted separately

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_a  in  N  operand A
cmd_b  in  N  operand B
cmd_ops  in  2*MAX_OPS  op_val program; step i = cmd_ops[2i+:2]
cmd_op_count  in  $clog2(MAX_OPS+1)  steps to run, 0..MAX_OPS
rsp_valid  out  1  one-cycle pulse, result ready
rsp_result  out  N  captured result
rsp_error  out  1  qualifies rsp_valid; 1 = timeout
busy  out  1  not IDLE
link_start  out  1  to core start
link_input_enable  out  1  to core input_enable
link_a  out  N_WIDTH  to core a
link_b  out  N_WIDTH  to core b
link_op_val  out  2  to core op_val
link_state  in  4  core state_res: S0..S7 = 0..7, IDLE = 8, INPUT = 9, OUTPUT = 10
link_output_valid  in  1  core output_valid
link_out  in  N_WIDTH  core result nibble

Behaviour:
- Synchronous active-high reset, and the same on every rst cycle mid-operation:
  - state = IDLE, all counters 0, rsp_result 0.
  - rsp_valid, rsp_error, busy and all link_* outputs = 0.
  - cmd_ready = 1 after reset.
- Link outputs are Moore-decoded from registered state and counters. The only exception is link_op_val in STEER, which is combinational from link_state.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch cmd_*, then go to START.
  - The capture register is cleared on accept.
- START (1 cycle): link_start = 1 -> LOAD.
- LOAD (exactly 16 cycles, nib = 0..15):
  - link_input_enable = 1.
  - link_a = A[nib*4+:4], link_b = B[nib*4+:4], least-significant nibble first.
  - After nib 15: go to OPS, or STEER if op_count = 0.
  - The core is in S0 on the first post-LOAD cycle.
- OPS (op_count cycles):
  - link_op_val = ops[idx], idx 0..op_count-1.
  - Then STEER.
- STEER: link_op_val = f(link_state), mapped as below. This forms a fixed path to OUTPUT of at most 5 hops.
  - S0 -> 2
  - S1 -> 2
  - S2 -> 2
  - S3 -> 2
  - S4 -> 1
  - S5 -> 0
  - S6 -> 0
  - S7 -> 0
  - any other state -> 0
- Steering cycles also update the core result; this is part of the defined op semantics.
- STEER exit:
  - link_state = 10 -> CAPTURE on the same cycle. The capture logic samples link_output_valid from that cycle onward.
  - More than TIMEOUT cycles -> RESP with error.
- CAPTURE:
  - Each cycle with link_output_valid = 1, store link_out into result[k*4+:4] and increment k.
  - After k = 15 is stored -> RESP.
  - Cycles with link_output_valid = 0 are not stored.
  - More than TIMEOUT cycles -> RESP with error.
- RESP (1 cycle):
  - rsp_valid = 1 and rsp_result is valid.
  - rsp_error = 1 only on timeout; in that case rsp_result holds the partial capture.
  - Then IDLE.
  - There is no response backpressure.
- Boundary conditions:
  - cmd_op_count > MAX_OPS is clamped to MAX_OPS.
  - cmd_valid outside IDLE is ignored (cmd_ready = 0).
  - The nibble counter and capture counter do not wrap.

Decomposition:
- Package fsm_link_pkg holds the following, shared with the core's testbench:
  - link_state_e enum (S0..S7, IDLE, INPUT, OUTPUT with the encodings above).
  - host_state_e enum (IDLE, START, LOAD, OPS, STEER, CAPTURE, RESP).
  - NIBBLES = N/N_WIDTH.
  - steer function.
- Sub-module fsm_link_deser holds the capture shift/index register plus its timeout counter.

Test Plan:
1. Setup: the core is freshly reset before each scenario.
2. cmd_a = 64'h10, cmd_b = 64'h30, op_count = 0 -> path S0 -> S4 -> OUTPUT; rsp_result = 64'h50, rsp_error = 0. Also checks link_start at t0 and LOAD nibble order, e.g. link_b = 3 at nib 1.
3. Same operands, ops = [3], op_count = 1 -> path S0 -> S1 -> S5 -> S4 -> OUTPUT; rsp_result = 64'h30.
4. Stub core: link_state held at 9 -> rsp_valid with rsp_error = 1 after TIMEOUT STEER cycles; busy drops on the next cycle.
5. Stub core: enter state 10 and present link_out = 0..F with one output_valid gap -> rsp_result = 64'hFEDCBA9876543210.
6. rst asserted during LOAD nib 5 -> all link_* outputs 0 on the next cycle, cmd_ready = 1, no rsp_valid. A new command with cmd_valid held high during busy is accepted exactly once.
